// File: rtl/sobel_ctrl_master.sv
// Sobel filter control-bus sequencer.
//
// Programs the filter over a single-outstanding AXI4-Lite master port: image
// size, interrupt enables and ap_start; then waits for the filter interrupt,
// clears it, reads AP_CTRL back into status and reports done/error.
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   cmd_start                  one-cycle run request, honoured only when idle
//   cmd_rows, cmd_cols         image dimensions, latched on an accepted start
//   busy, done, error          run in progress, one-cycle completion, sticky fault
//   status                     last AP_CTRL read data
//   interrupt                  level interrupt from the filter
//   m_axi_CONTROL_BUS_*        AXI4-Lite master (AW, W, B, AR, R channels)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for cmd_start
// AW_W     | write address and data offered, each until its own handshake
// B        | waiting for the write response
// WAIT_IRQ | filter running; counting cycles until interrupt or timeout
// AR       | AP_CTRL read address offered
// R        | waiting for read data
// DONE     | done pulse high for this single cycle
module sobel_ctrl_master #(
    parameter int C_M_AXI_CONTROL_BUS_ADDR_WIDTH = 5,
    parameter int C_M_AXI_CONTROL_BUS_DATA_WIDTH = 32,
    parameter int TIMEOUT_W                      = 24
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic                                        cmd_start,
    input  logic [31:0]                                 cmd_rows,
    input  logic [31:0]                                 cmd_cols,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        error,
    output logic [31:0]                                 status,
    input  logic                                        interrupt,
    output logic [C_M_AXI_CONTROL_BUS_ADDR_WIDTH-1:0]   m_axi_CONTROL_BUS_AWADDR,
    output logic                                        m_axi_CONTROL_BUS_AWVALID,
    input  logic                                        m_axi_CONTROL_BUS_AWREADY,
    output logic [C_M_AXI_CONTROL_BUS_DATA_WIDTH-1:0]   m_axi_CONTROL_BUS_WDATA,
    output logic [C_M_AXI_CONTROL_BUS_DATA_WIDTH/8-1:0] m_axi_CONTROL_BUS_WSTRB,
    output logic                                        m_axi_CONTROL_BUS_WVALID,
    input  logic                                        m_axi_CONTROL_BUS_WREADY,
    input  logic [1:0]                                  m_axi_CONTROL_BUS_BRESP,
    input  logic                                        m_axi_CONTROL_BUS_BVALID,
    output logic                                        m_axi_CONTROL_BUS_BREADY,
    output logic [C_M_AXI_CONTROL_BUS_ADDR_WIDTH-1:0]   m_axi_CONTROL_BUS_ARADDR,
    output logic                                        m_axi_CONTROL_BUS_ARVALID,
    input  logic                                        m_axi_CONTROL_BUS_ARREADY,
    input  logic [C_M_AXI_CONTROL_BUS_DATA_WIDTH-1:0]   m_axi_CONTROL_BUS_RDATA,
    input  logic [1:0]                                  m_axi_CONTROL_BUS_RRESP,
    input  logic                                        m_axi_CONTROL_BUS_RVALID,
    output logic                                        m_axi_CONTROL_BUS_RREADY
);

    localparam int AW = C_M_AXI_CONTROL_BUS_ADDR_WIDTH;
    localparam int DW = C_M_AXI_CONTROL_BUS_DATA_WIDTH;

    // Write sequence positions; ISR clear is the last write, after the interrupt.
    localparam logic [2:0] STEP_ROWS  = 3'd0;
    localparam logic [2:0] STEP_START = 3'd4;
    localparam logic [2:0] STEP_ISR   = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        AW_W,
        B,
        WAIT_IRQ,
        AR,
        R,
        DONE
    } state_t;

    state_t               state;
    logic [2:0]           step;
    logic [31:0]          rows;
    logic [31:0]          cols;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [AW-1:0]        aw_addr;
    logic [DW-1:0]        w_data;
    logic                 aw_valid;
    logic                 w_valid;
    logic                 b_ready;
    logic                 ar_valid;
    logic                 r_ready;

    function automatic logic [AW-1:0] step_addr(input logic [2:0] s);
        case (s)
            3'd0:    return AW'(8'h14);  // rows
            3'd1:    return AW'(8'h1C);  // cols
            3'd2:    return AW'(8'h04);  // GIE
            3'd3:    return AW'(8'h08);  // IER
            3'd4:    return AW'(8'h00);  // AP_CTRL
            default: return AW'(8'h0C);  // ISR
        endcase
    endfunction

    function automatic logic [DW-1:0] step_data(input logic [2:0] s,
                                                 input logic [31:0] r,
                                                 input logic [31:0] c);
        case (s)
            3'd0:    return DW'(r);
            3'd1:    return DW'(c);
            default: return DW'(32'd1);
        endcase
    endfunction

    assign cnt_inc = cnt + TIMEOUT_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            step     <= STEP_ROWS;
            rows     <= '0;
            cols     <= '0;
            cnt      <= '0;
            aw_addr  <= '0;
            w_data   <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            b_ready  <= 1'b0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            status   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        rows     <= cmd_rows;
                        cols     <= cmd_cols;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        step     <= STEP_ROWS;
                        aw_addr  <= step_addr(STEP_ROWS);
                        w_data   <= step_data(STEP_ROWS, cmd_rows, cmd_cols);
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        state    <= AW_W;
                    end
                end
                AW_W: begin
                    // A channel whose valid is already low has completed its handshake.
                    if (aw_valid && m_axi_CONTROL_BUS_AWREADY) aw_valid <= 1'b0;
                    if (w_valid && m_axi_CONTROL_BUS_WREADY) w_valid <= 1'b0;
                    if ((!aw_valid || m_axi_CONTROL_BUS_AWREADY) &&
                        (!w_valid || m_axi_CONTROL_BUS_WREADY)) begin
                        b_ready <= 1'b1;
                        state   <= B;
                    end
                end
                B: begin
                    if (m_axi_CONTROL_BUS_BVALID) begin
                        b_ready <= 1'b0;
                        if (m_axi_CONTROL_BUS_BRESP != 2'b00) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else if (step == STEP_START) begin
                            cnt   <= '0;
                            state <= WAIT_IRQ;
                        end else if (step == STEP_ISR) begin
                            ar_valid <= 1'b1;
                            state    <= AR;
                        end else begin
                            step     <= step + 3'd1;
                            aw_addr  <= step_addr(step + 3'd1);
                            w_data   <= step_data(step + 3'd1, rows, cols);
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            state    <= AW_W;
                        end
                    end
                end
                WAIT_IRQ: begin
                    if (interrupt) begin
                        step     <= STEP_ISR;
                        aw_addr  <= step_addr(STEP_ISR);
                        w_data   <= step_data(STEP_ISR, rows, cols);
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        state    <= AW_W;
                    end else if (&cnt_inc) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                AR: begin
                    if (m_axi_CONTROL_BUS_ARREADY) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= R;
                    end
                end
                R: begin
                    if (m_axi_CONTROL_BUS_RVALID) begin
                        r_ready <= 1'b0;
                        status  <= m_axi_CONTROL_BUS_RDATA[31:0];
                        // Bit 1 is ap_done; a finished filter must report it.
                        if ((m_axi_CONTROL_BUS_RRESP != 2'b00) || !m_axi_CONTROL_BUS_RDATA[1])
                            error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m_axi_CONTROL_BUS_AWADDR  = aw_addr;
    assign m_axi_CONTROL_BUS_AWVALID = aw_valid;
    assign m_axi_CONTROL_BUS_WDATA   = w_data;
    assign m_axi_CONTROL_BUS_WSTRB   = '1;
    assign m_axi_CONTROL_BUS_WVALID  = w_valid;
    assign m_axi_CONTROL_BUS_BREADY  = b_ready;
    assign m_axi_CONTROL_BUS_ARADDR  = '0;  // only AP_CTRL is ever read
    assign m_axi_CONTROL_BUS_ARVALID = ar_valid;
    assign m_axi_CONTROL_BUS_RREADY  = r_ready;

endmodule

// File: doc/sobel_ctrl_master.md
SOBEL_CTRL_MASTER -- requirements
Module: sobel_ctrl_master

Interface
REQ-001 SHALL have parameter C_M_AXI_CONTROL_BUS_ADDR_WIDTH, default 5, control-bus byte address width.
REQ-002 SHALL have parameter C_M_AXI_CONTROL_BUS_DATA_WIDTH, default 32, control-bus data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_W, default 24, width of the interrupt-wait timeout counter.
REQ-004 SHALL have ports, in order:
aclk  in  1  sole clock, all logic rising-edge.
aresetn  in  1  asynchronous active-low reset.
cmd_start  in  1  one-cycle run request.
cmd_rows, cmd_cols  in  32 each  image dimensions, sampled on an accepted cmd_start.
busy  out  1  sequence in progress.
done  out  1  one-cycle completion pulse.
error  out  1  sticky fault flag.
status  out  32  last AP_CTRL read data.
interrupt  in  1  level interrupt from the filter.
m_axi_CONTROL_BUS_AWADDR/AWVALID/AWREADY  out/out/in  5/1/1  write address.
m_axi_CONTROL_BUS_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data; WSTRB fixed 4'hF.
m_axi_CONTROL_BUS_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response.
m_axi_CONTROL_BUS_ARADDR/ARVALID/ARREADY  out/out/in  5/1/1  read address.
m_axi_CONTROL_BUS_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data.

Function
REQ-005 SHALL implement states IDLE, AW_W, B, WAIT_IRQ, AR, R, DONE.
REQ-006 SHALL accept cmd_start only in IDLE; SHALL ignore it in all other states; acceptance latches rows/cols, clears error, sets busy in the next cycle.
REQ-007 SHALL issue writes in this fixed order: 0x14<-rows, 0x1C<-cols, 0x04 (GIE)<-1, 0x08 (IER)<-1, 0x00 (AP_CTRL)<-1; after the AP_CTRL write it SHALL enter WAIT_IRQ.
REQ-008 AW_W: SHALL assert AWVALID and WVALID in the same cycle; SHALL hold each, with address/data stable, until its own READY is sampled high; SHALL deassert each independently; SHALL go to B once both have handshaken (same or different cycles).
REQ-009 B: SHALL hold BREADY high until BVALID; BRESP != 2'b00 SHALL set error and go to DONE; otherwise SHALL go to the next step.
REQ-010 WAIT_IRQ: SHALL count cycles; interrupt high SHALL lead to a write of 0x0C (ISR)<-1 (toggle clear), then a read of 0x00; when the counter reaches all-ones, SHALL set error and go to DONE without further bus traffic.
REQ-011 AR/R: SHALL hold ARVALID until ARREADY, then hold RREADY until RVALID; SHALL latch RDATA into status; RRESP != 0 or RDATA[1] (ap_done) == 0 SHALL set error.
REQ-012 DONE: SHALL pulse done for exactly one cycle, clear busy, and return to IDLE.
REQ-013 SHALL never have more than one outstanding transaction; SHALL never assert AWVALID/WVALID and ARVALID simultaneously.
REQ-014 An interrupt outside WAIT_IRQ SHALL be ignored.

Reset
REQ-015 aresetn low SHALL force IDLE asynchronously; all VALID/READY outputs, busy, done, error = 0; status = 0; counter = 0; mid-transaction reset SHALL abandon the transaction with no retry.

Verification
REQ-016 rows=480, cols=640, slave always ready, interrupt at cycle 200 -> writes 0x14=480, 0x1C=640, 0x04=1, 0x08=1, 0x00=1, 0x0C=1, then read 0x00 returning 0x6 -> status=0x6, done 1 cycle, error=0.
REQ-017 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles with AWADDR stable, exactly one B handshake.
REQ-018 BRESP=2'b10 on GIE write -> no further writes, error=1, done pulse, busy=0.
REQ-019 TIMEOUT_W=4, interrupt never asserted -> error=1 after 15 WAIT_IRQ cycles, done pulse, no ISR write.
REQ-020 cmd_start repeated while busy -> ignored; aresetn low during AW_W -> AWVALID/WVALID=0 immediately, IDLE, busy=0.
